// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM transaction scheduler: op codes,
// FSM state encodings, balance limit and account-index helper.
package atm_pkg;

  localparam int BAL_LIMIT = 2048;
  localparam int ACC_IDX_W = 4;
  localparam int AMT_W     = 11;
  localparam int OP_W      = 2;

  typedef enum logic [1:0] {
    OP_BAL  = 2'd0,
    OP_WDR  = 2'd1,
    OP_DEP  = 2'd2,
    OP_XFER = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_SRC = 3'd1,
    ST_RD_DST = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WR_DST = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  function automatic logic acc_bad(input logic [ACC_IDX_W-1:0] idx, input int num_acc);
    return int'(idx) >= num_acc;
  endfunction

endpackage

// File: rtl/atm_txn_scheduler_if.sv
// Terminal-side request/response bundle for atm_txn_scheduler.
// Per-terminal fields are packed side by side, terminal 0 in the low slice.
interface atm_txn_scheduler_if import atm_pkg::*; #(
  parameter int N_TERM = 2
);
  logic [N_TERM-1:0]           req_valid;
  logic [OP_W*N_TERM-1:0]      req_op;
  logic [ACC_IDX_W*N_TERM-1:0] req_src;
  logic [ACC_IDX_W*N_TERM-1:0] req_dst;
  logic [AMT_W*N_TERM-1:0]     req_amt;
  logic [N_TERM-1:0]           req_ready;
  logic [N_TERM-1:0]           rsp_valid;
  logic                        rsp_err;
  logic [AMT_W-1:0]            rsp_balance;

  modport master (
    output req_valid, req_op, req_src, req_dst, req_amt,
    input  req_ready, rsp_valid, rsp_err, rsp_balance
  );

  modport slave (
    input  req_valid, req_op, req_src, req_dst, req_amt,
    output req_ready, rsp_valid, rsp_err, rsp_balance
  );
endinterface

// File: rtl/atm_grant_arb.sv
// Terminal grant arbiter: combinational pick plus the latched winner index.
// ATM_RR_ARB_EN selects round-robin; otherwise fixed priority (lowest index wins).
module atm_grant_arb #(
  parameter  int N_TERM = 2,
  localparam int IDX_W  = (N_TERM > 1) ? $clog2(N_TERM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_TERM-1:0] req_valid_i,
  input  logic              advance_i,
  output logic              any_o,
  output logic [IDX_W-1:0]  gnt_idx_o,
  output logic [IDX_W-1:0]  gnt_q_o
);

  logic [IDX_W-1:0] gnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
    end else if (advance_i) begin
      gnt_q <= gnt_idx_o;
    end
  end

  assign gnt_q_o = gnt_q;

`ifdef ATM_RR_ARB_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  int               k;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (int'(gnt_idx_o) == N_TERM - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Search starts at the pointer and wraps; first requester found wins.
  always_comb begin
    any_o     = 1'b0;
    gnt_idx_o = '0;
    k         = 0;
    for (int i = 0; i < N_TERM; i++) begin
      k = (int'(ptr_q) + i) % N_TERM;
      if (!any_o && req_valid_i[k]) begin
        any_o     = 1'b1;
        gnt_idx_o = IDX_W'(k);
      end
    end
  end
`else
  always_comb begin
    any_o     = 1'b0;
    gnt_idx_o = '0;
    for (int i = N_TERM - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        any_o     = 1'b1;
        gnt_idx_o = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/atm_txn_scheduler.sv
// Serialises terminal transactions onto one single-port balance RAM using
// read-check-write sequencing. Arbitration mode follows ATM_RR_ARB_EN (see atm_grant_arb).
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | wait for request, grant, latch fields, read src or reject
// RD_SRC    | capture src balance; XFER also reads dst
// RD_DST    | capture dst balance
// EXEC      | evaluate rules; write src unless error or BAL
// WR_DST    | write dst + amt (XFER only)
// RESP      | one-cycle response to the granted terminal
module atm_txn_scheduler import atm_pkg::*; #(
  parameter int N_TERM  = 2,
  parameter int NUM_ACC = 10,
  parameter int BAL_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  atm_txn_scheduler_if.slave   term,
  output logic                 mem_rd_o,
  output logic                 mem_wr_o,
  output logic [ACC_IDX_W-1:0] mem_addr_o,
  output logic [BAL_W-1:0]     mem_wdata_o,
  input  logic [BAL_W-1:0]     mem_rdata_i
);

  localparam int IDX_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;
  localparam int CW    = BAL_W + 1;

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [ACC_IDX_W-1:0]   src_q, src_d;
  logic [ACC_IDX_W-1:0]   dst_q, dst_d;
  logic [AMT_W-1:0]       amt_q, amt_d;
  logic [BAL_W-1:0]       src_bal_q, src_bal_d;
  logic [BAL_W-1:0]       dst_bal_q, dst_bal_d;
  logic                   err_q, err_d;
  logic [AMT_W-1:0]       rbal_q, rbal_d;

  logic                   any_req;
  logic                   advance;
  logic [IDX_W-1:0]       gnt_idx;
  logic [IDX_W-1:0]       gnt_q;

  op_e                    sel_op;
  logic [ACC_IDX_W-1:0]   sel_src;
  logic [ACC_IDX_W-1:0]   sel_dst;
  logic [AMT_W-1:0]       sel_amt;
  logic                   sel_bad;

  logic [CW-1:0]          src_w, dst_w, amt_w;
  logic                   exec_err;
  logic [BAL_W-1:0]       new_src;
  logic [BAL_W-1:0]       new_dst;

  atm_grant_arb #(.N_TERM(N_TERM)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (term.req_valid),
    .advance_i   (advance),
    .any_o       (any_req),
    .gnt_idx_o   (gnt_idx),
    .gnt_q_o     (gnt_q)
  );

  assign sel_op  = op_e'(term.req_op[OP_W*gnt_idx +: OP_W]);
  assign sel_src = term.req_src[ACC_IDX_W*gnt_idx +: ACC_IDX_W];
  assign sel_dst = term.req_dst[ACC_IDX_W*gnt_idx +: ACC_IDX_W];
  assign sel_amt = term.req_amt[AMT_W*gnt_idx +: AMT_W];
  assign sel_bad = acc_bad(sel_src, NUM_ACC) ||
                   ((sel_op == OP_XFER) && (acc_bad(sel_dst, NUM_ACC) || (sel_dst == sel_src)));

  // Limits are checked one bit wider than the RAM word so sums cannot wrap.
  always_comb begin
    src_w    = CW'(src_bal_q);
    dst_w    = CW'(dst_bal_q);
    amt_w    = CW'(amt_q);
    exec_err = 1'b0;
    new_src  = src_bal_q;
    new_dst  = dst_bal_q + BAL_W'(amt_q);
    unique case (op_q)
      OP_WDR: begin
        exec_err = amt_w > src_w;
        new_src  = src_bal_q - BAL_W'(amt_q);
      end
      OP_DEP: begin
        exec_err = (src_w + amt_w) >= CW'(BAL_LIMIT);
        new_src  = src_bal_q + BAL_W'(amt_q);
      end
      OP_XFER: begin
        exec_err = (amt_w > src_w) || ((dst_w + amt_w) >= CW'(BAL_LIMIT));
        new_src  = src_bal_q - BAL_W'(amt_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    src_d            = src_q;
    dst_d            = dst_q;
    amt_d            = amt_q;
    src_bal_d        = src_bal_q;
    dst_bal_d        = dst_bal_q;
    err_d            = err_q;
    rbal_d           = rbal_q;
    advance          = 1'b0;
    term.req_ready   = '0;
    term.rsp_valid   = '0;
    term.rsp_err     = 1'b0;
    term.rsp_balance = '0;
    mem_rd_o         = 1'b0;
    mem_wr_o         = 1'b0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          advance        = 1'b1;
          term.req_ready = N_TERM'(1) << gnt_idx;
          op_d           = sel_op;
          src_d          = sel_src;
          dst_d          = sel_dst;
          amt_d          = sel_amt;
          if (sel_bad) begin
            err_d   = 1'b1;
            rbal_d  = '0;
            state_d = ST_RESP;
          end else begin
            mem_rd_o   = 1'b1;
            mem_addr_o = sel_src;
            state_d    = ST_RD_SRC;
          end
        end
      end
      ST_RD_SRC: begin
        src_bal_d = mem_rdata_i;
        if (op_q == OP_XFER) begin
          mem_rd_o   = 1'b1;
          mem_addr_o = dst_q;
          state_d    = ST_RD_DST;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_RD_DST: begin
        dst_bal_d = mem_rdata_i;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        err_d  = exec_err;
        rbal_d = exec_err ? src_bal_q[AMT_W-1:0] : new_src[AMT_W-1:0];
        if (exec_err || (op_q == OP_BAL)) begin
          state_d = ST_RESP;
        end else begin
          mem_wr_o    = 1'b1;
          mem_addr_o  = src_q;
          mem_wdata_o = new_src;
          state_d     = (op_q == OP_XFER) ? ST_WR_DST : ST_RESP;
        end
      end
      ST_WR_DST: begin
        mem_wr_o    = 1'b1;
        mem_addr_o  = dst_q;
        mem_wdata_o = new_dst;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        term.rsp_valid   = N_TERM'(1) << gnt_q;
        term.rsp_err     = err_q;
        term.rsp_balance = rbal_q;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_BAL;
      src_q     <= '0;
      dst_q     <= '0;
      amt_q     <= '0;
      src_bal_q <= '0;
      dst_bal_q <= '0;
      err_q     <= 1'b0;
      rbal_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      amt_q     <= amt_d;
      src_bal_q <= src_bal_d;
      dst_bal_q <= dst_bal_d;
      err_q     <= err_d;
      rbal_q    <= rbal_d;
    end
  end

endmodule
